// File: rtl/arbitro_pkg.sv
// Shared definitions for the VC pop scheduler: FSM state encodings, the
// default header bit used for destination steering, and counter widths.
package arbitro_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_PAUSE  = 2'd2
   } state_t;

   localparam int DEST_BIT_DEF = 8;
   localparam int CNT_W        = 8;
   // Wide enough for weights up to 15.
   localparam int STREAK_W     = 4;

endpackage

// File: rtl/vc_weight_grant.sv
// Weighted priority grant between the two virtual-channel FIFOs.
// vc0 may win up to VC0_WEIGHT consecutive grants while vc1 is waiting;
// after that vc1 gets one grant and the streak restarts.
// Ports:
//   empty_vc0, empty_vc1 : FIFO empty flags
//   pause_any            : any destination almost-full, suppresses all grants
//   streak               : current count of consecutive contested vc0 grants
//   grant_vc0, grant_vc1 : one-hot (or zero) grant for this cycle
//   streak_nxt           : streak value to load on the next edge
module vc_weight_grant
   import arbitro_pkg::*;
#(
   parameter int VC0_WEIGHT = 4
) (
   input  logic                empty_vc0,
   input  logic                empty_vc1,
   input  logic                pause_any,
   input  logic [STREAK_W-1:0] streak,
   output logic                grant_vc0,
   output logic                grant_vc1,
   output logic [STREAK_W-1:0] streak_nxt
);

   localparam logic [STREAK_W-1:0] WEIGHT = STREAK_W'(VC0_WEIGHT);

   always_comb begin
      grant_vc0  = 1'b0;
      grant_vc1  = 1'b0;
      streak_nxt = streak;
      if (!pause_any) begin
         if (!empty_vc0 && !empty_vc1) begin
            if (streak < WEIGHT) begin
               grant_vc0  = 1'b1;
               streak_nxt = streak + 1'b1;
            end else begin
               grant_vc1  = 1'b1;
               streak_nxt = '0;
            end
         end else if (!empty_vc0) begin
            grant_vc0  = 1'b1;
            streak_nxt = '0;
         end else if (!empty_vc1) begin
            grant_vc1  = 1'b1;
            streak_nxt = '0;
         end
      end
   end

endmodule

// File: rtl/arbitro_vc_pop.sv
// Read-side scheduler for the vc0/vc1 FIFOs. Pops one word per cycle under
// weighted priority, stalls while any destination is almost-full, steers the
// word to d0/d1 by data[DEST_BIT] two cycles after the pop, and counts words
// pushed to each destination.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   fifo_empty_vc0/1               : source FIFO empty flags
//   data_mux_0/1                   : source FIFO read data (valid cycle after pop)
//   pause_d0/1                     : destination almost-full
//   pop_vc0/1                      : combinational pops to the source FIFOs
//   data_out, push_d0/1            : registered word and destination pushes
//   state_o                        : FSM state (IDLE=0, ACTIVE=1, PAUSE=2)
//   idle                           : IDLE with nothing in flight
//   cnt_d0/1                       : wrapping per-destination word counters
module arbitro_vc_pop
   import arbitro_pkg::*;
#(
   parameter int DATA_SIZE  = 10,
   parameter int DEST_BIT   = DEST_BIT_DEF,
   parameter int VC0_WEIGHT = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fifo_empty_vc0,
   input  logic                 fifo_empty_vc1,
   input  logic [DATA_SIZE-1:0] data_mux_0,
   input  logic [DATA_SIZE-1:0] data_mux_1,
   input  logic                 pause_d0,
   input  logic                 pause_d1,
   output logic                 pop_vc0,
   output logic                 pop_vc1,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 push_d0,
   output logic                 push_d1,
   output logic [1:0]           state_o,
   output logic                 idle,
   output logic [CNT_W-1:0]     cnt_d0,
   output logic [CNT_W-1:0]     cnt_d1
);

   logic                 pause_any;
   logic                 any_ne;
   logic                 grant_vc0;
   logic                 grant_vc1;
   logic [STREAK_W-1:0]  streak;
   logic [STREAK_W-1:0]  streak_nxt;
   logic                 vld_p0;
   logic                 sel_p0;
   logic [DATA_SIZE-1:0] word_p1;
   state_t               state;

   assign pause_any = pause_d0 | pause_d1;
   assign any_ne    = !fifo_empty_vc0 || !fifo_empty_vc1;

   vc_weight_grant #(
      .VC0_WEIGHT (VC0_WEIGHT)
   ) u_grant (
      .empty_vc0  (fifo_empty_vc0),
      .empty_vc1  (fifo_empty_vc1),
      .pause_any  (pause_any),
      .streak     (streak),
      .grant_vc0  (grant_vc0),
      .grant_vc1  (grant_vc1),
      .streak_nxt (streak_nxt)
   );

   // Pops follow the inputs directly, not the FSM, so the first pop can
   // happen while the state still reads IDLE.
   assign pop_vc0 = grant_vc0 && !reset;
   assign pop_vc1 = grant_vc1 && !reset;

   // Stage p1: read data from the FIFO selected one cycle earlier.
   assign word_p1 = sel_p0 ? data_mux_1 : data_mux_0;

   // Stage p0 (pop registered) and output stage (word pushed).
   always_ff @(posedge clk) begin
      if (reset) begin
         streak   <= '0;
         vld_p0   <= 1'b0;
         sel_p0   <= 1'b0;
         data_out <= '0;
         push_d0  <= 1'b0;
         push_d1  <= 1'b0;
         cnt_d0   <= '0;
         cnt_d1   <= '0;
      end else begin
         streak  <= streak_nxt;
         vld_p0  <= pop_vc0 | pop_vc1;
         sel_p0  <= pop_vc1;
         push_d0 <= 1'b0;
         push_d1 <= 1'b0;
         if (vld_p0) begin
            data_out <= word_p1;
            if (word_p1[DEST_BIT]) begin
               push_d1 <= 1'b1;
               cnt_d1  <= cnt_d1 + 1'b1;
            end else begin
               push_d0 <= 1'b1;
               cnt_d0  <= cnt_d0 + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_ne && !pause_any) state <= ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (pause_any)    state <= ST_PAUSE;
               else if (!any_ne) state <= ST_IDLE;
            end
            ST_PAUSE: begin
               if (!pause_any) state <= any_ne ? ST_ACTIVE : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign state_o = state;
   assign idle    = (state == ST_IDLE) && !vld_p0 && !push_d0 && !push_d1;

endmodule

// File: doc/arbitro_vc_pop.md
# arbitro_vc_pop

Read-side scheduler for the two virtual-channel FIFOs (vc0, vc1) fed by the classification stage. Pops words from vc0/vc1 under weighted priority and stalls all pops while any destination FIFO signals pause. Steers each popped word to destination d0 or d1 by a header bit and keeps per-destination word counters. Sits between the VC FIFOs and the destination FIFOs.

## Interface
- DATA_SIZE, 10, word width.
- DEST_BIT, 8, bit of the word selecting destination (0 → d0, 1 → d1).
- VC0_WEIGHT, 4, maximum consecutive vc0 grants while vc1 is non-empty; 1..15.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- fifo_empty_vc0  in  1  vc0 FIFO empty.
- fifo_empty_vc1  in  1  vc1 FIFO empty.
- data_mux_0  in  DATA_SIZE  vc0 FIFO read data, valid the cycle after pop_vc0.
- data_mux_1  in  DATA_SIZE  vc1 FIFO read data, valid the cycle after pop_vc1.
- pause_d0  in  1  destination d0 almost-full.
- pause_d1  in  1  destination d1 almost-full.
- pop_vc0  out  1  combinational pop to vc0.
- pop_vc1  out  1  combinational pop to vc1.
- data_out  out  DATA_SIZE  registered word to destinations.
- push_d0  out  1  registered push to d0.
- push_d1  out  1  registered push to d1.
- state_o  out  2  FSM state: IDLE=0, ACTIVE=1, PAUSE=2.
- idle  out  1  IDLE and nothing in flight.
- cnt_d0  out  8  words pushed to d0, wraps 255→0.
- cnt_d1  out  8  words pushed to d1, wraps 255→0.

## Operation
- pause_any = pause_d0 | pause_d1. No pop in any cycle where pause_any or reset is high.
- Grant in cycle t, when no pause:
  - Both VCs non-empty and streak < VC0_WEIGHT: grant vc0, streak += 1.
  - Both VCs non-empty and streak == VC0_WEIGHT: grant vc1, streak = 0.
  - Only vc0 non-empty: grant vc0, streak = 0.
  - Only vc1 non-empty: grant vc1, streak = 0.
  - Neither non-empty: no grant; streak holds.
- At most one pop per cycle. A pop is never issued to an empty FIFO.
- The pipeline valid bit and VC select are registered on each pop.
- One cycle after a pop, the word from the selected FIFO is registered into data_out. push_d0 or push_d1 is set per data[DEST_BIT], and the matching counter increments on the same edge.
- FSM transitions, evaluated every edge:
  - IDLE → ACTIVE: any VC non-empty and !pause_any.
  - ACTIVE → PAUSE: pause_any.
  - ACTIVE → IDLE: both VCs empty and !pause_any.
  - PAUSE → ACTIVE: !pause_any and any VC non-empty.
  - PAUSE → IDLE: !pause_any and both VCs empty.
- Pop is gated by inputs, not by state, so the first pop can occur while state_o is still IDLE.
- Words already in flight when pause rises are still delivered.

## Timing
- Reset values: state IDLE, streak 0, pipeline valid 0, data_out 0, push_d0/push_d1 0, cnt_d0/cnt_d1 0, idle 1. pop_vc0/pop_vc1 are 0 while reset is high.
- Latency from pop (cycle t) to push (cycle t+2) is 2 cycles. Sustained throughput is 1 word/cycle.
- FIFO contract: read data is registered and valid at t+1. The empty flag reflects the pop at t+1.
- Pause contract: after pause_any rises, at most 2 more pushes occur (from pops at t-1 and t-2). Destination almost-full thresholds must leave ≥2 free slots.
- Reset asserted mid-operation: in-flight words are discarded and no push occurs in the cycle after reset; counters clear.
- push_d0 and push_d1 are never high together.

## Structure
- Shared package `arbitro_pkg`: FSM state encodings, DEST_BIT default, counter width (8).
- One sub-module, `vc_weight_grant`: empty flags, pause_any, and the streak register in; grant_vc0/grant_vc1 and streak update out.
- Top level holds the FSM, the 2-stage pop→push pipeline, and the counters.

## Test plan
- Reset, then vc0 holds 3 words with data[8]=0 and vc1 is empty → pops in cycles 1-3, push_d0 in cycles 3-5, cnt_d0=3, idle returns to 1.
- Both VCs hold 6 words each, VC0_WEIGHT=4 → pop order vc0×4, vc1, vc0×2, vc1×5; cnt totals 12.
- Continuous traffic, pause_d1 raised at cycle 10 for 5 cycles → no pops in cycles 10-14, ≤2 pushes after cycle 10, state_o=PAUSE, resumes with no data loss.
- Mixed data[8] from vc1 → each word reaches only the matching push. Run 256 d0 words → cnt_d0 wraps to 0.
- Reset asserted for 1 cycle while 2 words are in flight → no pushes afterwards, counters 0, state IDLE, pops resume the next cycle if non-empty.
- vc0 holds exactly 1 word → exactly one pop, with no back-to-back pop on the now-empty FIFO.
